// File: rtl/id_exe_pipe_reg_if.sv
// Purpose : ID->EXE bundle: ID handshake, decoded fields, EXE copies, hazard status, perf counters.
// Latency : none, wires only.
// Backpressure: exe_ready_in goes from EXE into the register. id_ready_out goes from the register back to ID.
// Ports   : master = ID/EXE environment side, slave = id_exe_pipe_reg side.
interface id_exe_pipe_reg_if #(
  parameter int ARQ              = 16,
  parameter int MEMORY_ADDR_SIZE = 13,
  parameter int NUM_SRC          = 3,
  parameter int REG_ADDR_W       = 4
);
  // ID side
  logic                          id_valid_in;
  logic                          id_ready_out;
  logic                          exe_ready_in;
  logic                          branch_taken;
  logic                          wb_en_in;
  logic                          rd_en_mem_in;
  logic                          wr_en_mem_in;
  logic                          mux_in;
  logic                          mux_mem_in;
  logic                          jop_lsb_in;
  logic                          jenable_in;
  logic                          pc_en_in;
  logic [1:0]                    alu_op_in;
  logic [NUM_SRC*ARQ-1:0]        src_in;
  logic [ARQ-1:0]                imm_in;
  logic [MEMORY_ADDR_SIZE-1:0]   jaddr_in;
  logic [REG_ADDR_W-1:0]         rd_addr_in;
  logic [NUM_SRC*REG_ADDR_W-1:0] rs_addr_in;
  logic [NUM_SRC-1:0]            rs_used_in;

  // EXE side
  logic                          wb_en_exe_out;
  logic                          rd_en_mem_exe_out;
  logic                          wr_en_mem_exe_out;
  logic                          mux_exe_out;
  logic                          mux_mem_exe_out;
  logic                          jop_lsb_exe_out;
  logic                          jenable_exe_out;
  logic                          pc_en_exe_out;
  logic [1:0]                    alu_op_exe_out;
  logic [NUM_SRC*ARQ-1:0]        src_exe_out;
  logic [ARQ-1:0]                imm_exe_out;
  logic [MEMORY_ADDR_SIZE-1:0]   jaddr_exe_out;
  logic [REG_ADDR_W-1:0]         rd_addr_exe_out;
  logic [NUM_SRC*REG_ADDR_W-1:0] rs_addr_exe_out;
  logic [NUM_SRC-1:0]            rs_used_exe_out;
  logic                          exe_valid_out;
  logic                          hazard_stall_out;
  logic [15:0]                   hazard_cnt_out;
  logic [15:0]                   flush_cnt_out;

  modport master (
    output id_valid_in, exe_ready_in, branch_taken,
    output wb_en_in, rd_en_mem_in, wr_en_mem_in, mux_in, mux_mem_in,
    output jop_lsb_in, jenable_in, pc_en_in, alu_op_in,
    output src_in, imm_in, jaddr_in, rd_addr_in, rs_addr_in, rs_used_in,
    input  id_ready_out,
    input  wb_en_exe_out, rd_en_mem_exe_out, wr_en_mem_exe_out, mux_exe_out,
    input  mux_mem_exe_out, jop_lsb_exe_out, jenable_exe_out, pc_en_exe_out,
    input  alu_op_exe_out, src_exe_out, imm_exe_out, jaddr_exe_out,
    input  rd_addr_exe_out, rs_addr_exe_out, rs_used_exe_out,
    input  exe_valid_out, hazard_stall_out, hazard_cnt_out, flush_cnt_out
  );

  modport slave (
    input  id_valid_in, exe_ready_in, branch_taken,
    input  wb_en_in, rd_en_mem_in, wr_en_mem_in, mux_in, mux_mem_in,
    input  jop_lsb_in, jenable_in, pc_en_in, alu_op_in,
    input  src_in, imm_in, jaddr_in, rd_addr_in, rs_addr_in, rs_used_in,
    output id_ready_out,
    output wb_en_exe_out, rd_en_mem_exe_out, wr_en_mem_exe_out, mux_exe_out,
    output mux_mem_exe_out, jop_lsb_exe_out, jenable_exe_out, pc_en_exe_out,
    output alu_op_exe_out, src_exe_out, imm_exe_out, jaddr_exe_out,
    output rd_addr_exe_out, rs_addr_exe_out, rs_used_exe_out,
    output exe_valid_out, hazard_stall_out, hazard_cnt_out, flush_cnt_out
  );
endinterface

// File: rtl/id_exe_pipe_reg.sv
// Purpose : ARQ-bit ID->EXE pipeline register. It has a valid bit, downstream hold, branch flush,
//           and a load-use bubble FSM.
// Latency : 1 cycle from acceptance (id_valid_in & id_ready_out) to the EXE outputs.
// Backpressure: while exe_ready_in=0 all outputs and FSM state hold (branch_taken still flushes).
//           id_ready_out drops during hazard bubbles.
// Ports   : clk, rst (sync, active-low). Everything else goes through bus (id_exe_pipe_reg_if.slave).
// Option  : define ID_EXE_PERF_CNT_EN to build the saturating hazard/flush counters.
//           Without it, hazard_cnt_out and flush_cnt_out read 0.
module id_exe_pipe_reg #(
  parameter int ARQ               = 16,
  parameter int MEMORY_ADDR_SIZE  = 13,
  parameter int NUM_SRC           = 3,
  parameter int REG_ADDR_W        = 4,
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  id_exe_pipe_reg_if.slave    bus
);

  localparam int CNT_W = 3;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  // Everything latched into EXE. An all-zero value is a bubble.
  typedef struct packed {
    logic                          valid;
    logic                          wb_en;
    logic                          rd_en_mem;
    logic                          wr_en_mem;
    logic                          mux;
    logic                          mux_mem;
    logic                          jop_lsb;
    logic                          jenable;
    logic                          pc_en;
    logic [1:0]                    alu_op;
    logic [NUM_SRC*ARQ-1:0]        src;
    logic [ARQ-1:0]                imm;
    logic [MEMORY_ADDR_SIZE-1:0]   jaddr;
    logic [REG_ADDR_W-1:0]         rd_addr;
    logic [NUM_SRC*REG_ADDR_W-1:0] rs_addr;
    logic [NUM_SRC-1:0]            rs_used;
  } exe_t;

  exe_t             ex_q;
  exe_t             ex_d;
  exe_t             id_pl;
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             src_match;
  logic             hazard;
  logic             hazard_stall;

  always_comb begin
    id_pl           = '0;
    id_pl.valid     = 1'b1;
    id_pl.wb_en     = bus.wb_en_in;
    id_pl.rd_en_mem = bus.rd_en_mem_in;
    id_pl.wr_en_mem = bus.wr_en_mem_in;
    id_pl.mux       = bus.mux_in;
    id_pl.mux_mem   = bus.mux_mem_in;
    id_pl.jop_lsb   = bus.jop_lsb_in;
    id_pl.jenable   = bus.jenable_in;
    id_pl.pc_en     = bus.pc_en_in;
    id_pl.alu_op    = bus.alu_op_in;
    id_pl.src       = bus.src_in;
    id_pl.imm       = bus.imm_in;
    id_pl.jaddr     = bus.jaddr_in;
    id_pl.rd_addr   = bus.rd_addr_in;
    id_pl.rs_addr   = bus.rs_addr_in;
    id_pl.rs_used   = bus.rs_used_in;
  end

  // A source that ID actually reads matches the destination of the load now in EXE.
  always_comb begin
    src_match = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.rs_used_in[i] &&
          (bus.rs_addr_in[i*REG_ADDR_W +: REG_ADDR_W] == ex_q.rd_addr)) begin
        src_match = 1'b1;
      end
    end
  end

  // Load data is not ready until after EXE. A dependent instruction in ID must wait.
  // Register 0 is hard-wired, so it never creates a dependency.
  assign hazard = (state_q == RUN) && ex_q.valid && ex_q.rd_en_mem && ex_q.wb_en &&
                  (ex_q.rd_addr != '0) && bus.id_valid_in && src_match;

  // A flush always completes in one edge, so ID is never blocked while branch_taken is high.
  assign bus.id_ready_out = bus.branch_taken |
                            (bus.exe_ready_in & (state_q == RUN) & ~hazard);
  assign hazard_stall     = ~bus.branch_taken & bus.exe_ready_in &
                            (hazard | (state_q == STALL));
  assign bus.hazard_stall_out = hazard_stall;

  always_comb begin
    ex_d    = ex_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.branch_taken) begin
      ex_d    = '0;
      state_d = RUN;
      cnt_d   = '0;
    end else if (bus.exe_ready_in) begin
      if (hazard) begin
        ex_d = '0;
        // The hazard edge is the first bubble. STALL supplies the rest.
        if (LOAD_STALL_CYCLES > 1) begin
          state_d = STALL;
          cnt_d   = CNT_W'(LOAD_STALL_CYCLES - 1);
        end
      end else if (state_q == STALL) begin
        ex_d = '0;
        if (cnt_q == CNT_W'(1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end else if (bus.id_valid_in) begin
        ex_d = id_pl;
      end else begin
        ex_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_q    <= '0;
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.exe_valid_out     = ex_q.valid;
  assign bus.wb_en_exe_out     = ex_q.wb_en;
  assign bus.rd_en_mem_exe_out = ex_q.rd_en_mem;
  assign bus.wr_en_mem_exe_out = ex_q.wr_en_mem;
  assign bus.mux_exe_out       = ex_q.mux;
  assign bus.mux_mem_exe_out   = ex_q.mux_mem;
  assign bus.jop_lsb_exe_out   = ex_q.jop_lsb;
  assign bus.jenable_exe_out   = ex_q.jenable;
  assign bus.pc_en_exe_out     = ex_q.pc_en;
  assign bus.alu_op_exe_out    = ex_q.alu_op;
  assign bus.src_exe_out       = ex_q.src;
  assign bus.imm_exe_out       = ex_q.imm;
  assign bus.jaddr_exe_out     = ex_q.jaddr;
  assign bus.rd_addr_exe_out   = ex_q.rd_addr;
  assign bus.rs_addr_exe_out   = ex_q.rs_addr;
  assign bus.rs_used_exe_out   = ex_q.rs_used;

`ifdef ID_EXE_PERF_CNT_EN
  logic [15:0] haz_cnt_q;
  logic [15:0] flush_cnt_q;

  // Each counter saturates rather than wraps, so a long run never reads as a small count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      haz_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hazard_stall && (haz_cnt_q != 16'hFFFF)) begin
        haz_cnt_q <= haz_cnt_q + 16'd1;
      end
      if (bus.branch_taken && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign bus.hazard_cnt_out = haz_cnt_q;
  assign bus.flush_cnt_out  = flush_cnt_q;
`else
  assign bus.hazard_cnt_out = 16'd0;
  assign bus.flush_cnt_out  = 16'd0;
`endif

endmodule
